dmem_arbiter: RTL
=================

# dmem_arbiter

Two-master arbiter that shares the single-port data memory between the CPU core (master 0) and an auxiliary master (master 1, e.g. program loader or debug port). It sits between the requesters and `data_memory`. It grants ownership through a small state machine with round-robin tie-breaking and a bounded burst length, drives the memory strobes from the owning master, and registers read data back to that master one cycle later.

## Interface
Parameters:
- `ADDR_W`, 5, address width (matches data memory depth of 32)
- `DATA_W`, 8, data width
- `MAX_BURST`, 4, accesses an owner may make before yielding to a pending other master (≥1)

Ports:
- `clk` input 1: single clock; all state on rising edge
- `reset` input 1: asynchronous, active-high
- `m0_req`, `m1_req` input 1: access request, held until granted
- `m0_wr`, `m1_wr` input 1: 1 = write, 0 = read
- `m0_addr`, `m1_addr` input ADDR_W: access address
- `m0_wdata`, `m1_wdata` input DATA_W: write data
- `m0_gnt`, `m1_gnt` output 1: access performed this cycle
- `m0_rvalid`, `m1_rvalid` output 1: registered read data valid (1-cycle pulse)
- `m0_rdata`, `m1_rdata` output DATA_W: registered read data, held until the next read by that master
- `mem_wr`, `mem_rd` output 1: memory write/read strobes
- `mem_addr` output ADDR_W, `mem_wdata` output DATA_W: to memory
- `mem_rdata` input DATA_W: combinational read data from memory

## Operation
- States: IDLE, OWN0, OWN1. Registers: `state`, `last` (last owner, 1 bit), `cnt` (burst count, saturates at MAX_BURST), `m0_rdata`, `m1_rdata`, `m0_rvalid`, `m1_rvalid`.
- IDLE: no grants; memory strobes 0. Next state:
  - only m0_req → OWN0; only m1_req → OWN1
  - both → the master ≠ `last`
  - none → IDLE
  - On entering OWNx: `last`←x, `cnt`←0.
- OWNx: `mx_gnt = mx_req` (combinational from state and request); other master's gnt = 0.
  - When `mx_gnt`=1: mem_addr/mem_wdata = mx's; mem_wr = mx_wr; mem_rd = ~mx_wr; `cnt`←min(cnt+1, MAX_BURST).
  - Handoff: if `mx_gnt` and cnt+1 ≥ MAX_BURST and other req=1 → OWNother (cnt←0, last←other).
  - If mx_req=0 → OWNother if other req, else IDLE. No memory access in that cycle.
  - Otherwise stay in OWNx.
- Memory outputs when no grant: mem_wr=0, mem_rd=0, mem_addr=0, mem_wdata=0.
- Read return: on an edge where mx_gnt=1 and mx_wr=0, `mx_rdata`←mem_rdata and `mx_rvalid`←1. Otherwise `mx_rvalid`←0 and `mx_rdata` holds.
- Writes: the memory commits them on the same edge; no response beyond gnt.

## Timing
- Reset (async, immediate): state=IDLE, last=1 (m0 wins the first tie), cnt=0, all rdata=0, all rvalid=0. All gnt and mem strobes go to 0 combinationally.
- Grant latency from IDLE: 1 cycle. Request seen in cycle N → gnt in cycle N+1.
- Back-to-back accesses by the owner: one per cycle, no bubbles.
- Handoff on burst limit: the other master's gnt begins in the cycle after the owner's MAX_BURST-th access. No dead cycle.
- Handoff on owner release: one dead cycle (the owner's req=0 cycle), then the other master's gnt.
- Read data latency: rvalid/rdata appear in the cycle after gnt.
- With MAX_BURST=1 and both masters requesting continuously, grants alternate every cycle.
- Owner alone: continues indefinitely; cnt saturates and never wraps.
- Reset asserted mid-burst: the current access is aborted (mem_wr drops before the edge); no rvalid is produced for it.

## Test plan
- Reset then m0 read of addr 3 (memory holds 0x5A): m0_req in cycle 1 → m0_gnt cycle 2, mem_rd=1, mem_addr=3 → m0_rvalid=1 with m0_rdata=0x5A in cycle 3, rvalid=0 in cycle 4.
- Both masters request in the same cycle from reset → m0 granted first. After m0 releases and both request again from IDLE → m1 granted (round-robin).
- MAX_BURST=4: m0 streams writes to addr 0..7 while m1 requests continuously → m0_gnt for exactly 4 cycles, then m1_gnt the next cycle. m1 then keeps ownership for 4 accesses, and m0 resumes after that.
- m1 alone issues 10 consecutive reads → m1_gnt on 10 consecutive cycles, cnt saturates at 4, no ownership change; 10 rvalid pulses, each one cycle after its gnt.
- Write 0xC3 to addr 31 via m1, then read addr 31 via m0 → m0_rdata=0xC3. m1_rdata keeps its prior value and m1_rvalid stays 0.
- Assert reset during m0's 2nd write of a burst → m0_gnt and mem_wr=0 immediately. After reset release with both masters requesting → m0 is granted after 1 cycle.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU core
// (master 0) and an auxiliary master (master 1). Ownership is granted by a
// three-state FSM with round-robin tie-breaking and a bounded burst length.
// The owner's request drives the memory strobes combinationally, and read
// data is registered back to that master one cycle after its grant.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   mX_req/wr/addr/wdata        master X access request (held until granted)
//   mX_gnt                      access performed this cycle
//   mX_rvalid/rdata             registered read return (rvalid is a 1-cycle pulse)
//   mem_wr/rd/addr/wdata        strobes to the data memory (all 0 when idle)
//   mem_rdata                   combinational read data from the memory
module dmem_arbiter #(
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m0_gnt,
    output logic              m1_gnt,
    output logic              m0_rvalid,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
    // One spare bit so cnt+1 never wraps before the compare.
    localparam logic [CNT_W:0]   BURST_WIDE = (CNT_W + 1)'(MAX_BURST);
    localparam logic [CNT_W-1:0] BURST_SAT  = CNT_W'(MAX_BURST);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;

    logic [1:0]       state, state_nx;
    logic             last, last_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [CNT_W:0]   cnt_inc;
    logic             burst_done;

    assign cnt_inc    = {1'b0, cnt} + (CNT_W + 1)'(1);
    assign burst_done = (cnt_inc >= BURST_WIDE);

    always_comb begin
        state_nx = state;
        last_nx  = last;
        cnt_nx   = cnt;
        m0_gnt   = 1'b0;
        m1_gnt   = 1'b0;
        case (state)
            IDLE: begin
                // On a tie the master that did not own last wins.
                if (m0_req && (!m1_req || last)) begin
                    state_nx = OWN0;
                    last_nx  = 1'b0;
                    cnt_nx   = '0;
                end else if (m1_req) begin
                    state_nx = OWN1;
                    last_nx  = 1'b1;
                    cnt_nx   = '0;
                end
            end
            OWN0: begin
                if (m0_req) begin
                    m0_gnt = 1'b1;
                    cnt_nx = burst_done ? BURST_SAT : cnt_inc[CNT_W-1:0];
                    if (burst_done && m1_req) begin
                        state_nx = OWN1;
                        last_nx  = 1'b1;
                        cnt_nx   = '0;
                    end
                end else if (m1_req) begin
                    state_nx = OWN1;
                    last_nx  = 1'b1;
                    cnt_nx   = '0;
                end else begin
                    state_nx = IDLE;
                end
            end
            OWN1: begin
                if (m1_req) begin
                    m1_gnt = 1'b1;
                    cnt_nx = burst_done ? BURST_SAT : cnt_inc[CNT_W-1:0];
                    if (burst_done && m0_req) begin
                        state_nx = OWN0;
                        last_nx  = 1'b0;
                        cnt_nx   = '0;
                    end
                end else if (m0_req) begin
                    state_nx = OWN0;
                    last_nx  = 1'b0;
                    cnt_nx   = '0;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        mem_wr    = 1'b0;
        mem_rd    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (m0_gnt) begin
            mem_wr    = m0_wr;
            mem_rd    = ~m0_wr;
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
        end else if (m1_gnt) begin
            mem_wr    = m1_wr;
            mem_rd    = ~m1_wr;
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            last  <= 1'b1;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            last  <= last_nx;
            cnt   <= cnt_nx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m0_rdata  <= '0;
            m1_rdata  <= '0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
        end else begin
            m0_rvalid <= m0_gnt && !m0_wr;
            m1_rvalid <= m1_gnt && !m1_wr;
            if (m0_gnt && !m0_wr) begin
                m0_rdata <= mem_rdata;
            end
            if (m1_gnt && !m1_wr) begin
                m1_rdata <= mem_rdata;
            end
        end
    end

endmodule
